key_tx: RTL

Preamble-inserting IQ transmitter that is the transmit-side counterpart of `key_rx`. For each payload packet on its AXI-stream input, it emits the following, all at the radio sample rate and in the same packed complex format that `key_rx` consumes:
- a repeated BPSK LFSR training preamble;
- a zero-valued guard gap;
- the payload samples, passed through unmodified.

It sits between the payload sample source and the DUC/radio TX chain.

---
 rtl/key_tx.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/key_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : key_tx
// Purpose  : Prepends a repeated BPSK LFSR training preamble and a zero guard
//            gap to each payload packet of {I,Q} samples headed for the radio.
// Revision : 1.0 - initial release
// ============================================================================
module key_tx #(
    parameter int         DATA_WIDTH = 16,
    parameter int         SYM_LEN    = 64,
    parameter int         NREP       = 8,
    parameter int         GAP_LEN    = 16,
    parameter logic [6:0] LFSR_SEED  = 7'h7F
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    enable,
    input  logic [DATA_WIDTH-1:0]   amp,
    input  logic [2*DATA_WIDTH-1:0] in_tdata,
    input  logic                    in_tvalid,
    input  logic                    in_tlast,
    output logic                    in_tready,
    output logic [2*DATA_WIDTH-1:0] out_tdata,
    output logic                    out_tvalid,
    output logic                    out_tlast,
    input  logic                    out_tready,
    output logic                    busy
);

    localparam int c_pre_total = SYM_LEN * NREP;
    localparam int c_pre_w     = $clog2(c_pre_total + 1);
    localparam int c_sym_w     = $clog2(SYM_LEN + 1);
    localparam int c_gap_w     = (GAP_LEN > 0) ? $clog2(GAP_LEN + 1) : 1;

    localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(c_pre_total - 1);
    localparam logic [c_sym_w-1:0] c_sym_last = c_sym_w'(SYM_LEN - 1);
    localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PREAMBLE = 2'd1,
        S_GAP      = 2'd2,
        S_PAYLOAD  = 2'd3
    } state_t;

    localparam state_t c_after_pre = (GAP_LEN > 0) ? S_GAP : S_PAYLOAD;

    state_t                  r_state;
    logic [DATA_WIDTH-1:0]   r_amp;
    logic [6:0]              r_lfsr;
    logic [c_pre_w-1:0]      r_pre_cnt;
    logic [c_sym_w-1:0]      r_sym_cnt;
    logic [c_gap_w-1:0]      r_gap_cnt;

    logic                    w_load;
    logic                    w_start;
    logic                    w_pre_step;
    logic [DATA_WIDTH-1:0]   w_amp_src;
    logic [DATA_WIDTH-1:0]   w_pre_i;
    logic                    w_sym_wrap;
    logic [6:0]              w_lfsr_next;
    logic [c_sym_w-1:0]      w_sym_next;
    logic                    w_pre_done;

    assign w_load     = !out_tvalid || out_tready;
    assign w_start    = (r_state == S_IDLE) && enable && in_tvalid && w_load;
    assign w_pre_step = w_start || ((r_state == S_PREAMBLE) && w_load);

    // The first preamble sample leaves on the start edge, before amp is latched.
    assign w_amp_src  = (r_state == S_IDLE) ? amp : r_amp;
    assign w_pre_i    = r_lfsr[6] ? ({DATA_WIDTH{1'b0}} - w_amp_src) : w_amp_src;

    assign w_sym_wrap  = (r_sym_cnt == c_sym_last);
    assign w_lfsr_next = w_sym_wrap ? LFSR_SEED : {r_lfsr[5:0], r_lfsr[6] ^ r_lfsr[5]};
    assign w_sym_next  = w_sym_wrap ? '0 : r_sym_cnt + 1'b1;
    assign w_pre_done  = (r_pre_cnt == c_pre_last);

    assign in_tready = (r_state == S_PAYLOAD) && w_load;
    assign busy      = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_state    <= S_IDLE;
            r_amp      <= '0;
            r_lfsr     <= LFSR_SEED;
            r_pre_cnt  <= '0;
            r_sym_cnt  <= '0;
            r_gap_cnt  <= '0;
            out_tdata  <= '0;
            out_tvalid <= 1'b0;
            out_tlast  <= 1'b0;
        end else if (w_pre_step) begin
            if (r_state == S_IDLE) begin
                r_amp <= amp;
            end
            out_tdata  <= {w_pre_i, {DATA_WIDTH{1'b0}}};
            out_tvalid <= 1'b1;
            out_tlast  <= 1'b0;
            r_lfsr     <= w_lfsr_next;
            r_sym_cnt  <= w_sym_next;
            if (w_pre_done) begin
                r_pre_cnt <= '0;
                r_state   <= c_after_pre;
            end else begin
                r_pre_cnt <= r_pre_cnt + 1'b1;
                r_state   <= S_PREAMBLE;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_load) begin
                        out_tvalid <= 1'b0;
                        out_tlast  <= 1'b0;
                    end
                end
                S_GAP: begin
                    if (w_load) begin
                        out_tdata  <= '0;
                        out_tvalid <= 1'b1;
                        out_tlast  <= 1'b0;
                        if (r_gap_cnt == c_gap_last) begin
                            r_gap_cnt <= '0;
                            r_state   <= S_PAYLOAD;
                        end else begin
                            r_gap_cnt <= r_gap_cnt + 1'b1;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (w_load) begin
                        if (in_tvalid) begin
                            out_tdata  <= in_tdata;
                            out_tvalid <= 1'b1;
                            out_tlast  <= in_tlast;
                            if (in_tlast) begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            out_tvalid <= 1'b0;
                            out_tlast  <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
